// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline: operand forwarding selects,
// load-use stall, branch flush, plus event FSM, saturating counters and stall watchdog.

module phu_fwd_sel (
  input  logic [4:0] src,
  input  logic       use_src,
  input  logic       exe_wreg,
  input  logic       exe_m2reg,
  input  logic [4:0] exe_rn,
  input  logic       mem_wreg,
  input  logic       mem_m2reg,
  input  logic [4:0] mem_rn,
  output logic [1:0] fwd,
  output logic       load_use
);
  logic hit_e, hit_m;

  always_comb begin
    hit_e    = exe_wreg && (exe_rn != 5'd0) && (exe_rn == src);
    hit_m    = mem_wreg && (mem_rn != 5'd0) && (mem_rn == src);
    fwd      = 2'b00;
    if (hit_e && !exe_m2reg)      fwd = 2'b01;
    else if (hit_m && !mem_m2reg) fwd = 2'b10;
    else if (hit_m)               fwd = 2'b11;
    // A load still in EXE has no data yet; the consumer must wait one cycle.
    load_use = use_src && hit_e && exe_m2reg;
  end
endmodule

module pipe_hazard_unit #(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 4
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_branch_taken,
  input  logic             exe_wreg,
  input  logic             exe_m2reg,
  input  logic [4:0]       exe_rn,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [4:0]       mem_rn,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             wpcir,
  output logic             bubble,
  output logic             flush_ifid,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             stall_err
);
  localparam int NUM_OPS = 2;
  localparam int SW      = $clog2(MAX_STALL + 1);
  localparam logic [SW:0]   RUN_LIM = (SW+1)'(MAX_STALL);
  localparam logic [SW-1:0] RUN_MAX = SW'(MAX_STALL);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    LSTALL = 2'b01,
    FLUSH  = 2'b10
  } state_e;

  logic [NUM_OPS-1:0][4:0] op_src;
  logic [NUM_OPS-1:0]      op_use;
  logic [NUM_OPS-1:0][1:0] op_fwd;
  logic [NUM_OPS-1:0]      op_lu;

  assign op_src = {id_rt, id_rs};
  assign op_use = {id_use_rt, id_use_rs};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    phu_fwd_sel u_sel (
      .src      (op_src[g]),
      .use_src  (op_use[g]),
      .exe_wreg (exe_wreg),
      .exe_m2reg(exe_m2reg),
      .exe_rn   (exe_rn),
      .mem_wreg (mem_wreg),
      .mem_m2reg(mem_m2reg),
      .mem_rn   (mem_rn),
      .fwd      (op_fwd[g]),
      .load_use (op_lu[g])
    );
  end

  logic load_hz, flush;

  // Control outputs are held at their safe values while reset is asserted.
  always_comb begin
    load_hz    = clrn && (|op_lu);
    flush      = clrn && id_branch_taken && !load_hz;
    fwda       = clrn ? op_fwd[0] : 2'b00;
    fwdb       = clrn ? op_fwd[1] : 2'b00;
    wpcir      = !load_hz;
    bubble     = load_hz;
    flush_ifid = flush;
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [SW-1:0]    run_q, run_d;
  logic             stall_err_q, stall_err_d;
  logic [SW:0]      run_inc;

  always_comb begin
    state_d = RUN;
    if (load_hz)    state_d = LSTALL;
    else if (flush) state_d = FLUSH;

    stall_cnt_d = stall_cnt_q;
    if (load_hz && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    flush_cnt_d = flush_cnt_q;
    if (flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;

    // Consecutive-stall run length, saturating at the watchdog limit.
    run_inc     = {1'b0, run_q} + 1'b1;
    run_d       = '0;
    if (load_hz) run_d = (run_inc >= RUN_LIM) ? RUN_MAX : run_inc[SW-1:0];
    stall_err_d = stall_err_q || (load_hz && (run_inc >= RUN_LIM));
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      run_q       <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      run_q       <= run_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign stall_err = stall_err_q;
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit built with 4-bit counters so saturation is reachable.

module tb_pipe_hazard_unit;
  localparam int CW = 4;

  typedef struct packed {
    logic [4:0] rs, rt;
    logic       use_rs, use_rt, br, ew, em;
    logic [4:0] ern;
    logic       mw, mm;
    logic [4:0] mrn;
  } in_t;

  typedef struct packed {
    logic [1:0]    fa, fb;
    logic          w, b, f;
    logic [1:0]    st;
    logic [CW-1:0] sc, fc;
    logic          err;
  } obs_t;

  logic clk = 1'b0, clrn = 1'b0;
  logic [4:0] id_rs, id_rt, exe_rn, mem_rn;
  logic id_use_rs, id_use_rt, id_branch_taken, exe_wreg, exe_m2reg, mem_wreg, mem_m2reg;
  logic [1:0] fwda, fwdb, state;
  logic wpcir, bubble, flush_ifid, stall_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int   n_run = 0, n_fail = 0;
  obs_t exp_q[$];
  obs_t obs, e;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.CNT_W(CW), .MAX_STALL(4)) dut (
    .clk(clk), .clrn(clrn), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_branch_taken(id_branch_taken), .exe_wreg(exe_wreg),
    .exe_m2reg(exe_m2reg), .exe_rn(exe_rn), .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg),
    .mem_rn(mem_rn), .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir), .bubble(bubble),
    .flush_ifid(flush_ifid), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .stall_err(stall_err)
  );

  assign obs = '{fa: fwda, fb: fwdb, w: wpcir, b: bubble, f: flush_ifid, st: state,
                 sc: stall_cnt, fc: flush_cnt, err: stall_err};

  function automatic in_t mk_in(input logic [4:0] rs, rt, input logic urs, urt, br, ew, em,
                                input logic [4:0] ern, input logic mw, mm, input logic [4:0] mrn);
    in_t i;
    i = '{rs: rs, rt: rt, use_rs: urs, use_rt: urt, br: br, ew: ew, em: em, ern: ern,
          mw: mw, mm: mm, mrn: mrn};
    return i;
  endfunction

  function automatic obs_t mk_exp(input logic [1:0] fa, fb, input logic w, b, f,
                                  input logic [1:0] st, input int sc, fc, input logic err);
    obs_t o;
    o = '{fa: fa, fb: fb, w: w, b: b, f: f, st: st, sc: CW'(sc), fc: CW'(fc), err: err};
    return o;
  endfunction

  // Load-use from a load to r8 consumed through rt.
  function automatic in_t lu_in(input logic br);
    return mk_in(5'd0, 5'd8, 1'b0, 1'b1, br, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 5'd0);
  endfunction

  task automatic drive(input in_t i);
    id_rs = i.rs; id_rt = i.rt; id_use_rs = i.use_rs; id_use_rt = i.use_rt;
    id_branch_taken = i.br; exe_wreg = i.ew; exe_m2reg = i.em; exe_rn = i.ern;
    mem_wreg = i.mw; mem_m2reg = i.mm; mem_rn = i.mrn;
  endtask

  task automatic do_reset();
    drive('0);
    clrn = 1'b0;
    #3;
    clrn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive(mk_in(5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 5'd8));
    exp_q.push_back(mk_exp(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 0, 0, 1'b0));
    #1;
    e = exp_q.pop_front();
    n_run++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_forced got %h expected %h", obs, e);
    end
    drive('0);
    #1 clrn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_forwarding();
    in_t  ins[7];
    obs_t exps[7];
    ins[0] = mk_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd5);
    exps[0] = mk_exp(2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 0, 0, 1'b0);
    ins[1] = mk_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd5);
    exps[1] = mk_exp(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 0, 0, 1'b0);
    ins[2] = mk_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd5);
    exps[2] = mk_exp(2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 0, 0, 1'b0);
    ins[3] = mk_in(5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd5);
    exps[3] = mk_exp(2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 0, 0, 1'b0);
    ins[4] = mk_in(5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'd5);
    exps[4] = mk_exp(2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 0, 0, 1'b0);
    ins[5] = mk_in(5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 5'd5);
    exps[5] = mk_exp(2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 0, 0, 1'b0);
    ins[6] = mk_in(5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0);
    exps[6] = mk_exp(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 0, 0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      drive(ins[k]);
      exp_q.push_back(exps[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL fwd[%0d] got %h expected %h", k, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    in_t  ins[3];
    obs_t exps[3];
    do_reset();
    ins[0] = lu_in(1'b0);
    exps[0] = mk_exp(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0, 1'b0);
    ins[1] = mk_in(5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 5'd8);
    exps[1] = mk_exp(2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 2'b01, 1, 0, 1'b0);
    ins[2] = '0;
    exps[2] = mk_exp(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 1, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(ins[k]);
      exp_q.push_back(exps[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL load_use[%0d] got %h expected %h", k, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_vs_stall();
    in_t  ins[3];
    obs_t exps[3];
    do_reset();
    ins[0] = lu_in(1'b1);
    exps[0] = mk_exp(2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 0, 0, 1'b0);
    ins[1] = mk_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    exps[1] = mk_exp(2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 2'b01, 1, 0, 1'b0);
    ins[2] = '0;
    exps[2] = mk_exp(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b10, 1, 1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drive(ins[k]);
      exp_q.push_back(exps[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL branch[%0d] got %h expected %h", k, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(k < 4 ? lu_in(1'b0) : in_t'('0));
      exp_q.push_back(mk_exp(2'b00, 2'b00, k >= 4, k < 4, 1'b0,
                             (k == 0 || k == 5) ? 2'b00 : 2'b01, k < 4 ? k : 4, 0, k >= 4));
      @(negedge clk);
      e = exp_q.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL watchdog[%0d] got %h expected %h", k, obs, e);
      end
      @(posedge clk); #1;
    end
    // Asynchronous clear mid-cycle, hazard inputs still active.
    drive(lu_in(1'b1));
    clrn = 1'b0;
    exp_q.push_back(mk_exp(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 0, 0, 1'b0));
    #1;
    e = exp_q.pop_front();
    n_run++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL midreset got %h expected %h", obs, e);
    end
    drive('0);
    #1 clrn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_watchdog_gap();
    int sc = 0, run = 0;
    logic err = 1'b0;
    logic [1:0] st = 2'b00;
    logic stall;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      stall = (k != 3) && (k != 7);
      drive(stall ? lu_in(1'b0) : in_t'('0));
      exp_q.push_back(mk_exp(2'b00, 2'b00, !stall, stall, 1'b0, st, sc, 0, err));
      @(negedge clk);
      e = exp_q.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL wd_gap[%0d] got %h expected %h", k, obs, e);
      end
      @(posedge clk); #1;
      sc  = sc + (stall ? 1 : 0);
      run = stall ? run + 1 : 0;
      err = err | (run >= 4);
      st  = stall ? 2'b01 : 2'b00;
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 18; k++) begin
      drive(k < 17 ? lu_in(1'b0) : in_t'('0));
      exp_q.push_back(mk_exp(2'b00, 2'b00, k == 17, k < 17, 1'b0, k == 0 ? 2'b00 : 2'b01,
                             k < 15 ? k : 15, 0, k >= 4));
      @(negedge clk);
      e = exp_q.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL stall_sat[%0d] got %h expected %h", k, obs, e);
      end
      @(posedge clk); #1;
    end
    for (int j = 0; j < 18; j++) begin
      drive(mk_in(5'd0, 5'd0, 1'b0, 1'b0, j < 17, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0));
      exp_q.push_back(mk_exp(2'b00, 2'b00, 1'b1, 1'b0, j < 17, j == 0 ? 2'b00 : 2'b10,
                             15, j < 15 ? j : 15, 1'b1));
      @(negedge clk);
      e = exp_q.pop_front();
      n_run++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL flush_sat[%0d] got %h expected %h", j, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    drive('0);
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_vs_stall();
    test_watchdog();
    test_watchdog_gap();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Hazard and forwarding controller for the 5-stage pipeline.
- Consumes the EXE-stage and MEM-stage control fields produced by the ID/EXE and EXE/MEM pipeline registers, together with the source registers of the instruction currently in ID.
- Drives the forwarding selects, the PC/IF-ID write enable, the bubble insert into the ID/EXE register, and the IF/ID flush.
- Tracks stall/flush events in an FSM with saturating event counters and a stuck-stall watchdog.

Parameters:
- CNT_W, 16, width of stall_cnt and flush_cnt.
- MAX_STALL, 4, consecutive stall cycles tolerated before stall_err sets.

Ports:
- clk  input  1  pipeline clock, rising edge
- clrn  input  1  asynchronous active-low reset
- id_rs  input  5  rs field of the instruction in ID
- id_rt  input  5  rt field of the instruction in ID
- id_use_rs  input  1  ID instruction reads rs
- id_use_rt  input  1  ID instruction reads rt (includes the store-data read)
- id_branch_taken  input  1  branch/jump resolved taken in ID
- exe_wreg  input  1  EXE instruction writes the register file
- exe_m2reg  input  1  EXE instruction is a load
- exe_rn  input  5  EXE destination register
- mem_wreg  input  1  MEM instruction writes the register file
- mem_m2reg  input  1  MEM instruction is a load
- mem_rn  input  5  MEM destination register
- fwda  output  2  rs operand select: 00 regfile, 01 EXE ALU result, 10 MEM ALU result, 11 MEM load data
- fwdb  output  2  rt operand select, same encoding as fwda
- wpcir  output  1  1 = PC and IF/ID may update; 0 = hold
- bubble  output  1  1 = zero the ID control fields entering ID/EXE
- flush_ifid  output  1  1 = replace the IF/ID contents with a NOP
- state  output  2  FSM state: 00 RUN, 01 LSTALL, 10 FLUSH
- stall_cnt  output  CNT_W  saturating count of stall cycles
- flush_cnt  output  CNT_W  saturating count of flush cycles
- stall_err  output  1  sticky watchdog error

Behaviour:

Clocking and reset:
- Single clock clk.
- Asynchronous active-low reset clrn: all registered state clears immediately when clrn=0, independent of clk.
- Reset values:
  - state=RUN
  - stall_cnt=0, flush_cnt=0, stall_err=0
  - internal consecutive-stall counter=0
- Combinational outputs while clrn=0: fwda=fwdb=00, wpcir=1, bubble=0, flush_ifid=0. The unit forces these values during reset regardless of its inputs.

Match definitions:
- hitE(r) = exe_wreg & (exe_rn!=0) & (exe_rn==r)
- hitM(r) = mem_wreg & (mem_rn!=0) & (mem_rn==r)
- Register 0 never matches.

Forwarding (combinational, zero latency):
- fwda for rs, evaluated in priority order:
  - hitE(rs) & ~exe_m2reg → 01
  - else hitM(rs) & ~mem_m2reg → 10
  - else hitM(rs) & mem_m2reg → 11
  - else → 00
- fwdb uses the same rules applied to rt.
- Forwarding outputs do not depend on id_use_*.

Load-use stall (combinational):
- load_hz = exe_m2reg & ((id_use_rs & hitE(rs)) | (id_use_rt & hitE(rt)))
- When load_hz=1: wpcir=0 and bubble=1.
- In the following cycle the load sits in MEM, so the same source resolves to 11.

Branch flush:
- flush_ifid = id_branch_taken & ~load_hz.
- If a stall and a taken branch occur in the same cycle, the stall wins. The branch is re-resolved next cycle with forwarded operands.

FSM (registered, updated on the rising edge of clk):
- From any state, next state is evaluated in this order:
  - load_hz → LSTALL
  - else flush_ifid → FLUSH
  - else → RUN
- LSTALL and FLUSH are informational. They do not gate any outputs.

Counters:
- stall_cnt increments each cycle load_hz=1.
- flush_cnt increments each cycle flush_ifid=1.
- Both saturate at all-ones and do not wrap.

Watchdog:
- The internal consecutive-stall counter increments while load_hz=1 and clears when load_hz=0.
- stall_err sets when the counter reaches MAX_STALL.
- stall_err stays set until clrn.

Mid-operation reset: asserting clrn in any state returns the unit to RUN on the next evaluation, with all counters and stall_err cleared.

Test Plan:
1. exe_wreg=1, exe_m2reg=0, exe_rn=5; id_rs=5; mem_wreg=1, mem_rn=5 → fwda=01 (EXE priority). Then set exe_wreg=0 → fwda=10.
2. Load-use: exe_m2reg=1, exe_wreg=1, exe_rn=8, id_rt=8, id_use_rt=1 → wpcir=0, bubble=1, state=LSTALL after the edge, stall_cnt=1. Next cycle drive exe_wreg=0 and mem_m2reg=1, mem_wreg=1, mem_rn=8 → wpcir=1, fwdb=11.
3. exe_rn=0 with exe_wreg=1 and id_rs=0 → fwda=00, no stall.
4. id_branch_taken=1 together with the load-use condition from scenario 2 → flush_ifid=0, wpcir=0. Next cycle with no hazard → flush_ifid=1, state=FLUSH, flush_cnt=1.
5. Hold load_hz=1 for 4 consecutive cycles → stall_err=1 after the 4th edge. Drop load_hz → stall_err stays 1. Pulse clrn=0 → stall_err=0, stall_cnt=0, state=RUN with no clock edge required.
6. Preload stall_cnt near saturation (CNT_W=4 build): 17 stall cycles → stall_cnt=15.
